// File: rtl/fta_bridge32to128_pkg.sv
// Shared bus types for the 32-to-128 bit FTA widening bridge, plus the tag-table
// entry type and the lane-select shift used by the bridge and its tag table.
package fta_bridge32to128_pkg;

  localparam int FTA_LANE32_SHIFT = 2;

  typedef logic [3:0] fta_cid_t;
  typedef logic [7:0] fta_tid_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [2:0]  pri;
    fta_cid_t    cid;
    fta_tid_t    tid;
    logic [31:0] vadr;
    logic [31:0] padr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } fta_cmd_request32_t;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [2:0]   pri;
    fta_cid_t     cid;
    fta_tid_t     tid;
    logic [31:0]  vadr;
    logic [31:0]  padr;
    logic [15:0]  sel;
    logic [127:0] data1;
  } fta_cmd_request128_t;

  typedef struct packed {
    fta_cid_t    cid;
    fta_tid_t    tid;
    logic [2:0]  pri;
    logic        ack;
    logic        err;
    logic        rty;
    logic        next;
    logic        stall;
    logic [31:0] adr;
    logic [31:0] dat;
  } fta_cmd_response32_t;

  typedef struct packed {
    fta_cid_t     cid;
    fta_tid_t     tid;
    logic [2:0]   pri;
    logic         ack;
    logic         err;
    logic         rty;
    logic         next;
    logic         stall;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;

  typedef struct packed {
    logic       valid;
    fta_cid_t   cid;
    fta_tid_t   tid;
    logic [1:0] lane;
  } fta_b32to128_tag_t;

endpackage

// File: rtl/fta_bridge32to128_if.sv
// Bus bundle between the 32-bit initiator, the bridge and the 128-bit target.
// slave: the bridge's view; master: the initiator/target side that drives it.
interface fta_bridge32to128_if;
  import fta_bridge32to128_pkg::*;

  fta_cmd_request32_t   req32_i;
  fta_cmd_response32_t  resp32_o;
  fta_cmd_request128_t  req128_o;
  fta_cmd_response128_t resp128_i;

  modport slave  (input  req32_i, input  resp128_i, output resp32_o, output req128_o);
  modport master (output req32_i, output resp128_i, input  resp32_o, input  req128_o);

endinterface

// File: rtl/fta_b32to128_tag_table.sv
// Outstanding-transaction table: lowest-free allocation, {cid,tid} match and free,
// and optional per-entry age counters (FTA_B32TO128_TIMEOUT_EN).
module fta_b32to128_tag_table
  import fta_bridge32to128_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alloc,
  input  fta_cid_t          alloc_cid,
  input  fta_tid_t          alloc_tid,
  input  logic [1:0]        alloc_lane,
  input  logic              rsp_valid,
  input  fta_cid_t          rsp_cid,
  input  fta_tid_t          rsp_tid,
  output logic              full,
  output logic              hit,
  output logic [1:0]        hit_lane,
  output logic              timeout_valid,
  output fta_b32to128_tag_t timeout_tag
);

  fta_b32to128_tag_t tags [DEPTH];
  logic [DEPTH-1:0]  free_vec, match_vec, alloc_oh, hit_oh, retire_oh;

  always_comb begin
    free_vec  = '0;
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i]  = ~tags[i].valid;
      match_vec[i] = tags[i].valid && (tags[i].cid == rsp_cid) && (tags[i].tid == rsp_tid);
    end
  end

  // x & -x isolates the lowest set bit: lowest free slot / lowest matching slot
  assign alloc_oh = free_vec & (~free_vec + DEPTH'(1));
  assign hit_oh   = rsp_valid ? (match_vec & (~match_vec + DEPTH'(1))) : '0;
  assign full     = ~|free_vec;
  assign hit      = |hit_oh;

  always_comb begin
    hit_lane = '0;
    for (int i = 0; i < DEPTH; i++)
      if (hit_oh[i]) hit_lane = tags[i].lane;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) tags[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc && alloc_oh[i])
          tags[i] <= '{valid: 1'b1, cid: alloc_cid, tid: alloc_tid, lane: alloc_lane};
        else if (hit_oh[i] || retire_oh[i])
          tags[i].valid <= 1'b0;
      end
    end
  end

`ifdef FTA_B32TO128_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

  logic [AGE_W-1:0] age [DEPTH];
  logic [DEPTH-1:0] aged_vec, aged_first;

  always_comb begin
    aged_vec = '0;
    for (int i = 0; i < DEPTH; i++)
      aged_vec[i] = tags[i].valid && (age[i] == AGE_MAX);
  end

  assign aged_first = aged_vec & (~aged_vec + DEPTH'(1));
  // A real response owns the return path this cycle; retirement waits one cycle
  assign timeout_valid = (|aged_vec) & ~rsp_valid;
  assign retire_oh     = timeout_valid ? aged_first : '0;

  always_comb begin
    timeout_tag = '0;
    for (int i = 0; i < DEPTH; i++)
      if (aged_first[i]) timeout_tag = tags[i];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc && alloc_oh[i])
          age[i] <= '0;
        else if (tags[i].valid && (age[i] != AGE_MAX))
          age[i] <= age[i] + AGE_W'(1);
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign retire_oh      = '0;
  assign timeout_valid  = 1'b0;
  assign timeout_tag    = '0;
`endif

endmodule

// File: rtl/fta_bridge32to128.sv
// 32-bit to 128-bit FTA widening bridge: lane-steered registered requests, tag-tracked
// responses with lane extraction. Optional entry timeout under FTA_B32TO128_TIMEOUT_EN.
module fta_bridge32to128
  import fta_bridge32to128_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fta_bridge32to128_if.slave bus
);

  fta_cmd_request128_t req128_q;
  fta_cmd_response32_t resp32_q;
  logic                req_hold, accept, rsp_valid, full, hit, timeout_valid;
  logic [1:0]          hit_lane, req_lane;
  fta_b32to128_tag_t   timeout_tag;
  logic                unused_tag;

  assign req_hold   = req128_q.stb & bus.resp128_i.stall;
  assign accept     = bus.req32_i.cyc & bus.req32_i.stb & ~full & ~req_hold;
  assign rsp_valid  = bus.resp128_i.ack | bus.resp128_i.err | bus.resp128_i.rty;
  assign req_lane   = bus.req32_i.padr[FTA_LANE32_SHIFT +: 2];
  assign unused_tag = ^{timeout_tag.valid, timeout_tag.lane};

  fta_b32to128_tag_table #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) u_tag_table (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc         (accept),
    .alloc_cid     (bus.req32_i.cid),
    .alloc_tid     (bus.req32_i.tid),
    .alloc_lane    (req_lane),
    .rsp_valid     (rsp_valid),
    .rsp_cid       (bus.resp128_i.cid),
    .rsp_tid       (bus.resp128_i.tid),
    .full          (full),
    .hit           (hit),
    .hit_lane      (hit_lane),
    .timeout_valid (timeout_valid),
    .timeout_tag   (timeout_tag)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req128_q <= '0;
    end else if (!req_hold) begin
      if (accept) begin
        req128_q.cyc   <= bus.req32_i.cyc;
        req128_q.stb   <= bus.req32_i.stb;
        req128_q.we    <= bus.req32_i.we;
        req128_q.pri   <= bus.req32_i.pri;
        req128_q.cid   <= bus.req32_i.cid;
        req128_q.tid   <= bus.req32_i.tid;
        req128_q.vadr  <= bus.req32_i.vadr;
        req128_q.padr  <= bus.req32_i.padr;
        req128_q.sel   <= 16'(bus.req32_i.sel) << {req_lane, 2'b00};
        req128_q.data1 <= {4{bus.req32_i.dat}};
      end else begin
        req128_q.cyc <= 1'b0;
        req128_q.stb <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp32_q <= '0;
    end else begin
      resp32_q.ack <= 1'b0;
      resp32_q.err <= 1'b0;
      resp32_q.rty <= 1'b0;
      if (rsp_valid) begin
        resp32_q.cid <= bus.resp128_i.cid;
        resp32_q.tid <= bus.resp128_i.tid;
        resp32_q.pri <= bus.resp128_i.pri;
        resp32_q.adr <= bus.resp128_i.adr;
        if (hit) begin
          resp32_q.ack  <= bus.resp128_i.ack;
          resp32_q.err  <= bus.resp128_i.err;
          resp32_q.rty  <= bus.resp128_i.rty;
          resp32_q.next <= bus.resp128_i.next;
          resp32_q.dat  <= bus.resp128_i.dat[{hit_lane, 5'b00000} +: 32];
        end else begin
          // Unknown {cid,tid}: report an error rather than drop the response
          resp32_q.err  <= 1'b1;
          resp32_q.next <= 1'b0;
          resp32_q.dat  <= bus.resp128_i.dat[31:0];
        end
      end else if (timeout_valid) begin
        resp32_q.cid  <= timeout_tag.cid;
        resp32_q.tid  <= timeout_tag.tid;
        resp32_q.pri  <= '0;
        resp32_q.adr  <= '0;
        resp32_q.next <= 1'b0;
        resp32_q.err  <= 1'b1;
        resp32_q.dat  <= '0;
      end
    end
  end

  always_comb begin
    bus.resp32_o       = resp32_q;
    bus.resp32_o.stall = full | req_hold;
  end

  assign bus.req128_o = req128_q;

endmodule
